// File: rtl/imem_loader.sv
// imem_loader: packs a big-endian byte stream into 32-bit instruction memory writes
// and holds the CPU in reset until the program is loaded.
module imem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int BOOT_HOLD  = 2
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH:0]   load_len,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);
  typedef enum logic [2:0] {IDLE, RECV, WRITE, HOLD, RUN} state_t;
  localparam logic [ADDR_WIDTH:0] MAX_LEN  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [3:0]          HOLD_END = 4'(BOOT_HOLD - 1);
  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   len_q, len_d, word_cnt_q, word_cnt_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [23:0]           word_q, word_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            hold_q, hold_d;
  logic                  error_q, error_d;
  logic                  len_bad;
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    hold_d     = hold_q;
    error_d    = error_q;
    len_bad    = load_len > MAX_LEN;
    case (state_q)
      IDLE, RUN: begin
        if (load_start && len_bad) error_d = 1'b1;
        else if (load_start) begin
          error_d    = 1'b0;
          len_d      = load_len;
          word_cnt_d = '0;
          byte_cnt_d = '0;
          addr_d     = '0;
          hold_d     = '0;
          state_d    = (load_len == '0) ? HOLD : RECV;
        end
      end
      RECV: begin
        if (byte_valid) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          word_d     = {word_q[15:0], byte_data};
          if (byte_cnt_q == 2'd3) begin
            wdata_d = {word_q, byte_data};
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        addr_d     = addr_q + 1'b1;
        word_cnt_d = word_cnt_q + 1'b1;
        byte_cnt_d = '0;
        hold_d     = '0;
        state_d    = (word_cnt_q + 1'b1 == len_q) ? HOLD : RECV;
      end
      HOLD: begin
        hold_d  = hold_q + 4'd1;
        state_d = (hold_q == HOLD_END) ? RUN : HOLD;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      len_q      <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      hold_q     <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      hold_q     <= hold_d;
      error_q    <= error_d;
    end
  end
  assign byte_ready = state_q == RECV;
  assign mem_we     = state_q == WRITE;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign cpu_reset  = state_q != RUN;
  assign busy       = state_q inside {RECV, WRITE, HOLD};
  assign done       = state_q == RUN;
  assign error      = error_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed loads with a write scoreboard checked by an independent monitor.
module tb_imem_loader;
  localparam int AW = 8;
  localparam int BH = 2;
  logic          CLK = 0, Reset = 0, load_start = 0, byte_valid = 0;
  logic [AW:0]   load_len = '0;
  logic [7:0]    byte_data = '0;
  logic          byte_ready, mem_we, cpu_reset, busy, done, error;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [39:0]   exp_q[$];
  int            total = 0, bad = 0, we_count = 0;
  imem_loader #(.ADDR_WIDTH(AW), .BOOT_HOLD(BH)) dut (
    .CLK(CLK), .Reset(Reset), .load_start(load_start), .load_len(load_len),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error)
  );
  always #5 CLK = ~CLK;
  always @(negedge CLK) begin
    if (Reset && mem_we) begin
      we_count++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_write got addr=%0h data=%08h, expected no write", mem_addr, mem_wdata);
      end else begin
        logic [39:0] e;
        e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== e) begin
          bad++;
          $display("FAIL sb_write got addr=%0h data=%08h, expected addr=%0h data=%08h",
                   mem_addr, mem_wdata, e[39:32], e[31:0]);
        end
      end
    end
  end
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask
  task automatic sync();
    @(posedge CLK);
    #1;
  endtask
  task automatic start(input int len);
    load_start = 1;
    load_len = (AW+1)'(len);
    sync();
    load_start = 0;
  endtask
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_valid = 1;
    byte_data = b;
    do begin @(negedge CLK); n++; end while (!byte_ready && n < 50);
    if (!byte_ready) chk("send_ready_timeout", byte_ready, 1);
    sync();
    byte_valid = 0;
  endtask
  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask
  task automatic check_release();
    int n = 0;
    do begin @(negedge CLK); n++; end while (!mem_we && n < 20);
    chk("last_we_seen", mem_we, 1);
    for (int k = 0; k < BH; k++) begin
      @(negedge CLK);
      chk("hold_cpu_reset", cpu_reset, 1);
    end
    @(negedge CLK);
    chk("released_cpu_reset_done", {cpu_reset, done}, 2'b01);
    sync();
  endtask
  task automatic wait_done();
    int n = 0;
    while (!done && n < 50) begin sync(); n++; end
    chk("wait_done", done, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int wc;
    repeat (3) sync();
    Reset = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      chk("idle_rst_rdy_we_done", {cpu_reset, byte_ready, mem_we, done}, 4'b1000);
    end
    sync();
    chk("idle_busy_error", {busy, error}, 2'b00);
    wc = we_count;
    start(257);
    chk("len257_error", error, 1);
    chk("len257_idle", {busy, done, cpu_reset, byte_ready}, 4'b0010);
    repeat (4) sync();
    chk("len257_no_write", we_count, wc);
    start(0);
    chk("len0_error_clear", error, 0);
    chk("len0_hold", {busy, done, cpu_reset}, 3'b101);
    sync();
    chk("len0_still_held", done, 0);
    sync();
    chk("len0_done", {done, cpu_reset, busy}, 3'b100);
    chk("len0_no_write", we_count, wc);
    exp_q.push_back({8'h00, 32'h20080005});
    exp_q.push_back({8'h01, 32'h8C090004});
    start(2);
    chk("run_reload_holds_cpu", {cpu_reset, done, byte_ready}, 3'b101);
    send_word(32'h20080005);
    send_word(32'h8C090004);
    check_release();
    chk("full_rate_writes", we_count, wc + 2);
    exp_q.push_back({8'h00, 32'h20080005});
    exp_q.push_back({8'h01, 32'h8C090004});
    start(2);
    send_byte(8'h20);
    send_byte(8'h08);
    for (int i = 0; i < 7; i++) begin
      @(negedge CLK);
      chk("gap_ready_held", {byte_ready, mem_we}, 2'b10);
      sync();
    end
    send_byte(8'h00);
    send_byte(8'h05);
    send_word(32'h8C090004);
    check_release();
    chk("gap_writes", we_count, wc + 4);
    exp_q.push_back({8'h00, 32'hDEADBEEF});
    start(2);
    send_word(32'hDEADBEEF);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    Reset = 0;
    #1;
    chk("async_rst_ctrl", {cpu_reset, byte_ready, mem_we, busy, done, error}, 6'b100000);
    chk("async_rst_addr", mem_addr, 0);
    chk("async_rst_wdata", mem_wdata, 0);
    sync();
    Reset = 1;
    sync();
    exp_q.push_back({8'h00, 32'h11223344});
    start(1);
    send_word(32'h11223344);
    check_release();
    exp_q.push_back({8'h00, 32'hAABBCCDD});
    start(1);
    chk("reload_cpu_held", {cpu_reset, done}, 2'b10);
    send_word(32'hAABBCCDD);
    chk("in_write", mem_we, 1);
    start(3);
    wait_done();
    repeat (10) sync();
    chk("ignored_start_no_reload", {done, busy, error}, 3'b100);
    start(300);
    chk("run_illegal_error", {error, done, cpu_reset}, 3'b110);
    chk("sb_empty", exp_q.size(), 0);
    chk("total_writes", we_count, wc + 7);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
